// File: rtl/regfile_multiport_if.sv
// Register file access bundle: pipeline-side master, array-side slave.
// Carries clear/ready handshake, write port and packed read ports.
interface regfile_multiport_if #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2
);
    logic                   clear_req;
    logic                   ready;
    logic                   clear_done;
    logic                   we;
    logic [AW-1:0]          waddr;
    logic [XLEN-1:0]        wdata;
    logic [NUM_RD*AW-1:0]   raddr;
    logic [NUM_RD*XLEN-1:0] rdata;

    modport master (
        output clear_req, we, waddr, wdata, raddr,
        input  ready, clear_done, rdata
    );

    modport slave (
        input  clear_req, we, waddr, wdata, raddr,
        output ready, clear_done, rdata
    );
endinterface

// File: rtl/regfile_multiport.sv
// Multi-read-port register file, x0 hardwired to zero, sequential clear engine.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_multiport #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2
) (
    input logic               clk,
    input logic               rst_n,
    regfile_multiport_if.slave rf
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {CLEAR, READY} state_t;

    state_t          state;
    logic [AW-1:0]   idx;
    logic            ready_q;
    logic            done_q;
    logic [XLEN-1:0] regs [DEPTH];
    logic [NUM_RD*XLEN-1:0] rdata;

    logic wr_ok;
    assign wr_ok = (state == READY) && rf.we &&
                   (rf.waddr != '0) && !rf.clear_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            idx     <= AW'(1);
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                CLEAR: begin
                    if (rf.clear_req) begin
                        // restart; the aborted sweep never reports done
                        idx <= AW'(1);
                    end else if (idx == AW'(DEPTH - 1)) begin
                        state   <= READY;
                        idx     <= AW'(1);
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                READY: begin
                    if (rf.clear_req) begin
                        state   <= CLEAR;
                        idx     <= AW'(1);
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    idx     <= AW'(1);
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // storage carries no reset; the sweep zeroes it instead
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            regs[idx] <= '0;
        end else if (wr_ok) begin
            regs[rf.waddr] <= rf.wdata;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;

        assign a = rf.raddr[p*AW +: AW];

        always_comb begin
            d = '0;
            if (ready_q && (a != '0)) begin
                d = regs[a];
`ifdef REGFILE_BYPASS_EN
                if (rf.we && (rf.waddr == a)) begin
                    d = rf.wdata;
                end
`endif
            end
        end

        assign rdata[p*XLEN +: XLEN] = d;
    end

    assign rf.rdata      = rdata;
    assign rf.ready      = ready_q;
    assign rf.clear_done = done_q;
endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: vector table plus clear/reset sequences.
// Expectations follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_multiport;
    localparam int XLEN   = 32;
    localparam int DEPTH  = 32;
    localparam int NUM_RD = 2;
    localparam int AW     = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic          we;
        logic [AW-1:0] waddr;
        logic [31:0]   wdata;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [31:0]   e0;
        logic [31:0]   e1;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    regfile_multiport_if #(.XLEN(XLEN), .AW(AW), .NUM_RD(NUM_RD)) rf ();

    regfile_multiport #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rf   (rf.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n, output int dones);
        n = 0;
        dones = 0;
        while (n < 100) begin
            step();
            n++;
            if (rf.clear_done) dones++;
            if (rf.ready) break;
        end
    endtask

    task automatic read2(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [31:0] e0, input logic [31:0] e1,
                         input string name);
        rf.raddr = {a1, a0};
        @(negedge clk);
        chk({name, "_p0"}, rf.rdata[31:0], e0);
        chk({name, "_p1"}, rf.rdata[63:32], e1);
        step();
    endtask

    vec_t vec[10];
    int   n;
    int   dn;
    int   dtot;

    initial begin
        vec[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd1,  5'd2,  32'h0, 32'h0};
        vec[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,
                   32'hDEADBEEF, 32'hDEADBEEF};
        vec[2] = '{1'b1, 5'd0,  32'h00001234, 5'd0,  5'd5,
                   32'h0, 32'hDEADBEEF};
        vec[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0};
        vec[4] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd5,
                   BYP ? 32'hA5A5A5A5 : 32'h0, 32'hDEADBEEF};
        vec[5] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd31,
                   32'hA5A5A5A5, 32'h0};
        vec[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd7,
                   BYP ? 32'hFFFFFFFF : 32'h0, 32'hA5A5A5A5};
        vec[7] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd30,
                   32'hFFFFFFFF, 32'h0};
        vec[8] = '{1'b1, 5'd1,  32'h11111111, 5'd1,  5'd1,
                   BYP ? 32'h11111111 : 32'h0,
                   BYP ? 32'h11111111 : 32'h0};
        vec[9] = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd31,
                   32'h11111111, 32'hFFFFFFFF};

        rf.clear_req = 1'b0;
        rf.we        = 1'b0;
        rf.waddr     = '0;
        rf.wdata     = '0;
        rf.raddr     = {5'd3, 5'd5};

        // reset state
        #12;
        chk("rst_ready", 32'(rf.ready), 32'd0);
        chk("rst_done", 32'(rf.clear_done), 32'd0);
        chk("rst_rd0", rf.rdata[31:0], 32'h0);
        chk("rst_rd1", rf.rdata[63:32], 32'h0);
        rst_n = 1'b1;
        wait_ready(n, dn);
        chk("init_sweep_len", 32'(n), 32'd31);
        chk("init_done_cnt", 32'(dn), 32'd1);
        chk("init_rd5", rf.rdata[31:0], 32'h0);
        chk("init_rd3", rf.rdata[63:32], 32'h0);
        step();
        chk("init_done_low", 32'(rf.clear_done), 32'd0);

        // table of write/read vectors
        for (int i = 0; i < 10; i++) begin
            rf.we    = vec[i].we;
            rf.waddr = vec[i].waddr;
            rf.wdata = vec[i].wdata;
            rf.raddr = {vec[i].ra1, vec[i].ra0};
            @(negedge clk);
            chk($sformatf("vec%0d_p0", i), rf.rdata[31:0], vec[i].e0);
            chk($sformatf("vec%0d_p1", i), rf.rdata[63:32], vec[i].e1);
            step();
        end
        rf.we = 1'b0;

        // clear_req with a write in the same cycle
        rf.clear_req = 1'b1;
        rf.we        = 1'b1;
        rf.waddr     = 5'd3;
        rf.wdata     = 32'h33333333;
        step();
        rf.clear_req = 1'b0;
        rf.we        = 1'b0;
        chk("clr_ready_low", 32'(rf.ready), 32'd0);
        rf.raddr = {5'd7, 5'd5};
        @(negedge clk);
        chk("clr_rd_busy", rf.rdata[63:32], 32'h0);
        wait_ready(n, dn);
        chk("clr_sweep_len", 32'(n - 0), 32'd31);
        chk("clr_done_cnt", 32'(dn), 32'd1);
        read2(5'd3, 5'd5, 32'h0, 32'h0, "clr_x3_x5");
        read2(5'd7, 5'd31, 32'h0, 32'h0, "clr_x7_x31");

        // clear_req again at sweep idx 10
        rf.clear_req = 1'b1;
        step();
        rf.clear_req = 1'b0;
        dtot = 0;
        for (int k = 0; k < 9; k++) begin
            step();
            if (rf.clear_done) dtot++;
        end
        rf.clear_req = 1'b1;
        step();
        rf.clear_req = 1'b0;
        if (rf.clear_done) dtot++;
        wait_ready(n, dn);
        dtot += dn;
        chk("restart_len", 32'(n), 32'd31);
        chk("restart_done_cnt", 32'(dtot), 32'd1);

        // async reset while READY
        rf.we    = 1'b1;
        rf.waddr = 5'd9;
        rf.wdata = 32'h00000099;
        step();
        rf.we = 1'b0;
        read2(5'd9, 5'd0, 32'h00000099, 32'h0, "x9_written");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(rf.ready), 32'd0);
        #3 rst_n = 1'b1;
        wait_ready(n, dn);
        chk("arst_sweep_len", 32'(n), 32'd31);

        // async reset mid-sweep, writes during sweep ignored
        rf.clear_req = 1'b1;
        step();
        rf.clear_req = 1'b0;
        rf.we    = 1'b1;
        rf.waddr = 5'd9;
        rf.wdata = 32'h0000005A;
        for (int k = 0; k < 12; k++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_ready", 32'(rf.ready), 32'd0);
        chk("mid_done", 32'(rf.clear_done), 32'd0);
        #3 rst_n = 1'b1;
        wait_ready(n, dn);
        rf.we = 1'b0;
        chk("mid_sweep_len", 32'(n), 32'd31);
        chk("mid_done_cnt", 32'(dn), 32'd1);
        read2(5'd9, 5'd9, 32'h0, 32'h0, "x9_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
